md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers, in the EX stage beside
//  the ALU. Accepts one op per start pulse, holds BUSY for a fixed latency, then
//  commits HI/LO. The hazard unit stalls mult/div/mfhi/mflo/mthi/mtlo in ID
//  while (Start | Busy).
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1      clock, rising edge
//  reset   in   1      asynchronous, active-high; clears all state
//  A       in   WIDTH  rs operand (forwarded)
//  B       in   WIDTH  rt operand (forwarded)
//  MDOp    in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  Start   in   1      one-cycle request; qualifies MDOp/A/B
//  Busy    out  1      operation in flight
//  HI      out  WIDTH  HI register (registered output)
//  LO      out  WIDTH  LO register (registered output)
// BEHAVIOUR
//  Reset: Busy=0, HI=0, LO=0, counter=0, state=IDLE. Asynchronous; takes effect
//   immediately. Reset mid-operation aborts the op and discards its result.
//  States: IDLE, RUN.
//  IDLE + Start + MDOp in {MULT,MULTU,DIV,DIVU}:
//   - latch A, B, and op
//   - load counter with MULT_CYCLES-1 or DIV_CYCLES-1
//   - go to RUN; Busy=1 from the next cycle
//  IDLE + Start + MTHI/MTLO: HI<=A or LO<=A at this edge. Busy stays 0.
//  IDLE + Start + MDOp 110/111: ignored, no state change.
//  RUN, counter!=0: decrement. HI/LO hold their old values.
//  RUN, counter==0: at this edge commit HI/LO, Busy<=0, go to IDLE. The new
//   values are visible the cycle after Busy falls.
//  Latency: Start at edge t -> Busy high for exactly N cycles -> HI/LO updated at
//   edge t+N (N = MULT_CYCLES or DIV_CYCLES).
//  Start during RUN: ignored entirely. Operands, op and counter are unchanged.
//   Upstream stalling is required to prevent it.
//  Start at the commit edge: ignored. A new op is accepted only in IDLE.
//  Arithmetic:
//   - MULTU: {HI,LO} = zero-extended 2*WIDTH product
//   - MULT: {HI,LO} = sign-extended 2*WIDTH product
//   - DIVU: LO = A/B, HI = A%B (unsigned)
//   - DIV: LO = quotient truncated toward zero; HI = remainder, sign follows
//     dividend
//   - DIV of -2^(WIDTH-1) by -1: LO = 0x80000000, HI = 0
//  Divide by zero (B==0 latched): full busy period still runs; HI/LO unchanged.
//  The result is computed from the latched operands, not live A/B. Operand
//   changes during RUN have no effect.
// STRUCTURE
//  Shared package/header md_defs: MDOp encodings (MD_MULT..MD_MTLO) and state
//   encodings. ALU decode uses the same header.
//  Sub-module md_arith (combinational): latched op/A/B -> {hi_res, lo_res, dz}.
//   It isolates the signed/unsigned product/quotient logic from the control FSM.
//  Top: FSM, down-counter ($clog2(max latency) bits), operand latches, HI/LO regs.
// TESTING
//  1 MULTU A=0xFFFFFFFF B=2, Start 1 cycle -> Busy=1 for 5 cycles; then
//    HI=0x00000001, LO=0xFFFFFFFE.
//  2 MULT A=-3 B=7 -> after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//    Change A,B mid-run -> result unchanged.
//  3 DIV A=-7 B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    DIVU A=7 B=2 -> LO=3, HI=1.
//  4 DIV A=5 B=0, HI=0x11 LO=0x22 prior -> Busy 10 cycles; HI=0x11, LO=0x22.
//  5 MTHI A=0xABCD0000, then MTLO A=0x1234 in consecutive cycles ->
//    HI=0xABCD0000, LO=0x1234, Busy never asserts.
//    Start MULT during RUN of DIV -> ignored, DIV result only.
//  6 Assert reset 3 cycles into MULT -> Busy=0, HI=LO=0 immediately.
//    New MULT after release -> correct result after 5 cycles.

Source files
------------

// File: rtl/md_unit_pkg.sv
// ----------------------------------------------------------------------------
// md_unit_pkg
//  Shared definitions for the multiply/divide unit and its decode logic:
//  MDOp encodings, FSM state encodings and small op-classification helpers.
// ----------------------------------------------------------------------------
package md_unit_pkg;

  // MDOp field encodings (3 bits); 110/111 are reserved and ignored
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_RSV6  = 3'b110,
    MD_RSV7  = 3'b111
  } md_op_t;

  // Control FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // Ops that occupy the unit for a multi-cycle busy period
  function automatic logic is_long_op(input md_op_t op);
    logic res;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Divide-class ops (select the divide latency and the divide-by-zero hold)
  function automatic logic is_div_op(input md_op_t op);
    logic res;
    case (op)
      MD_DIV, MD_DIVU: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

  // Ops that interpret operands as two's complement
  function automatic logic is_signed_op(input md_op_t op);
    logic res;
    case (op)
      MD_MULT, MD_DIV: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

  // Larger of two latencies, used to size the down-counter
  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_unit_arith.sv
// ----------------------------------------------------------------------------
// md_unit_arith
//  Purely combinational datapath: latched op/A/B -> HI/LO result and a
//  divide-by-zero flag. Keeps signed/unsigned product and quotient logic out
//  of the control FSM.
//  Ports:
//   op      in   md_op_t  latched operation
//   a, b    in   WIDTH    latched operands
//   hi_res  out  WIDTH    HI result (product high half / remainder)
//   lo_res  out  WIDTH    LO result (product low half / quotient)
//   dz      out  1        divisor is zero
// ----------------------------------------------------------------------------
module md_unit_arith
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             dz
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic                 sgn_s;
  logic [2*WIDTH-1:0]   ext_a_s;
  logic [2*WIDTH-1:0]   ext_b_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic [WIDTH-1:0]     divisor_s;
  logic [WIDTH-1:0]     q_mag_s;
  logic [WIDTH-1:0]     r_mag_s;
  logic [WIDTH-1:0]     quot_s;
  logic [WIDTH-1:0]     rem_s;

  // Multiply: one 2W x 2W multiplier truncated to 2W bits; sign-extending the
  // inputs makes the truncated unsigned product equal to the signed product.
  always_comb begin
    sgn_s   = is_signed_op(op);
    ext_a_s = sgn_s ? {{WIDTH{a[WIDTH-1]}}, a} : {ZERO_W, a};
    ext_b_s = sgn_s ? {{WIDTH{b[WIDTH-1]}}, b} : {ZERO_W, b};
    prod_s  = ext_a_s * ext_b_s;
  end

  // Divide on magnitudes then restore signs; this naturally yields
  // 0x80..0 / 0 for the most-negative / -1 case and never divides by zero.
  always_comb begin
    dz        = (b == ZERO_W);
    abs_a_s   = (sgn_s && a[WIDTH-1]) ? (~a + ONE_W) : a;
    abs_b_s   = (sgn_s && b[WIDTH-1]) ? (~b + ONE_W) : b;
    divisor_s = dz ? ONE_W : abs_b_s;
    q_mag_s   = abs_a_s / divisor_s;
    r_mag_s   = abs_a_s % divisor_s;
    quot_s    = (sgn_s && (a[WIDTH-1] ^ b[WIDTH-1])) ? (~q_mag_s + ONE_W) : q_mag_s;
    rem_s     = (sgn_s && a[WIDTH-1]) ? (~r_mag_s + ONE_W) : r_mag_s;
  end

  // Result select by op class
  always_comb begin
    hi_res = ZERO_W;
    lo_res = ZERO_W;
    case (op)
      MD_MULT, MD_MULTU: begin
        hi_res = prod_s[2*WIDTH-1:WIDTH];
        lo_res = prod_s[WIDTH-1:0];
      end
      MD_DIV, MD_DIVU: begin
        hi_res = rem_s;
        lo_res = quot_s;
      end
      default: begin
        hi_res = ZERO_W;
        lo_res = ZERO_W;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit
//  Multi-cycle multiply/divide unit with HI/LO registers. A Start pulse in
//  IDLE latches op and operands and holds Busy for a fixed latency, after
//  which HI/LO are committed. MTHI/MTLO write HI/LO directly in one cycle.
//  Ports:
//   clk    in   1      clock, rising edge
//   reset  in   1      asynchronous active-high reset
//   A, B   in   WIDTH  rs / rt operands
//   MDOp   in   3      operation select
//   Start  in   1      one-cycle request qualifying MDOp/A/B
//   Busy   out  1      operation in flight (registered)
//   HI,LO  out  WIDTH  HI/LO registers
// ----------------------------------------------------------------------------
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDOp,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = max_lat(MULT_CYCLES, DIV_CYCLES);
  localparam int CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  md_state_t        state_r;
  md_state_t        state_nxt_s;
  md_op_t           md_op_s;
  md_op_t           op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             cnt_zero_s;
  logic             accept_s;
  logic             commit_s;
  logic             mthi_s;
  logic             mtlo_s;
  logic [WIDTH-1:0] hi_res_s;
  logic [WIDTH-1:0] lo_res_s;
  logic             dz_s;

  assign md_op_s    = md_op_t'(MDOp);
  assign cnt_zero_s = (cnt_r == CNT_ZERO);

  md_unit_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .hi_res (hi_res_s),
    .lo_res (lo_res_s),
    .dz     (dz_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (commit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM control strobes; Start is only honoured in IDLE
  always_comb begin
    accept_s = 1'b0;
    commit_s = 1'b0;
    mthi_s   = 1'b0;
    mtlo_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = Start && is_long_op(md_op_s);
        mthi_s   = Start && (md_op_s == MD_MTHI);
        mtlo_s   = Start && (md_op_s == MD_MTLO);
      end
      ST_RUN: begin
        commit_s = cnt_zero_s;
      end
      default: begin
        accept_s = 1'b0;
        commit_s = 1'b0;
      end
    endcase
  end

  // Busy flag tracks the state entered at this edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Operand/op latches and latency down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r  <= MD_MULT;
      a_r   <= ZERO_W;
      b_r   <= ZERO_W;
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      op_r  <= md_op_s;
      a_r   <= A;
      b_r   <= B;
      cnt_r <= is_div_op(md_op_s) ? DIV_LOAD : MULT_LOAD;
    end else if ((state_r == ST_RUN) && !cnt_zero_s) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // HI/LO registers: commit at end of run (divide-by-zero leaves them), or
  // direct moves from A while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= ZERO_W;
      lo_r <= ZERO_W;
    end else if (commit_s) begin
      if (!(is_div_op(op_r) && dz_s)) begin
        hi_r <= hi_res_s;
        lo_r <= lo_res_s;
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end else if (mthi_s) begin
      hi_r <= A;
    end else if (mtlo_s) begin
      lo_r <= A;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// ----------------------------------------------------------------------------
// tb_md_unit
//  Bench for md_unit: directed scenarios with literal expectations plus a
//  randomized phase, all compared every cycle against a behavioural model
//  that computes results with 64-bit / integer arithmetic.
// ----------------------------------------------------------------------------
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic [2:0]  MDOp  = 3'd0;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors    = 0;
  int miscompares = 0;
  int bc;

  md_unit #(.WIDTH(32), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  int          m_rem = 0;           // cycles of busy left
  logic [64:0] m_pend = 65'd0;      // {keep_old, hi, lo}

  // Result of an op from plain arithmetic; bit 64 set means "leave HI/LO"
  function automatic logic [64:0] model_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          ia, ib, q, r;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, sp};
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return {1'b0, up};
      end
      OP_DIV: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q  = ia / ib;
        r  = ia % ib;
        return {1'b0, 32'(r), 32'(q)};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {1'b1, 64'd0};
        return {1'b0, a % b, a / b};
      end
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  // Model update on each clock edge or asynchronous reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
      m_rem <= 0;
    end else if (m_rem > 1) begin
      m_rem <= m_rem - 1;
    end else if (m_rem == 1) begin
      m_rem <= 0;
      if (!m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (Start) begin
      if (MDOp <= OP_DIVU) begin
        m_pend <= model_result(MDOp, A, B);
        m_rem  <= (MDOp >= OP_DIV) ? DIV_N : MULT_N;
      end else if (MDOp == OP_MTHI) begin
        m_hi <= A;
      end else if (MDOp == OP_MTLO) begin
        m_lo <= A;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      cmp("busy", {31'd0, Busy}, {31'd0, (m_rem != 0)});
      cmp("hi", HI, m_hi);
      cmp("lo", LO, m_lo);
    end
  end

  // Issue one op, scramble operands while busy, optionally inject a Start
  // at busy cycle inject_at; return the number of busy cycles seen
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int busy_cycles);
    @(negedge clk);
    MDOp = op; A = a; B = b; Start = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      Start = 1'b0;
      A = $urandom;
      B = $urandom;
      if (!Busy) break;
      busy_cycles++;
      if (busy_cycles == inject_at) begin
        Start = 1'b1;
        MDOp  = OP_MULT;
      end
    end
    Start = 1'b0;
    if (Busy) cmp("busy_timeout", {31'd0, Busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      5: return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    cmp("rst_busy", {31'd0, Busy}, 32'd0);
    cmp("rst_hi", HI, 32'd0);
    cmp("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: MULTU
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, -1, bc);
    cmp("t1_busy_len", 32'(bc), 32'd5);
    cmp("t1_hi", HI, 32'h0000_0001);
    cmp("t1_lo", LO, 32'hFFFF_FFFE);

    // 2: MULT with operands changing mid-run
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, bc);
    cmp("t2_busy_len", 32'(bc), 32'd5);
    cmp("t2_hi", HI, 32'hFFFF_FFFF);
    cmp("t2_lo", LO, 32'hFFFF_FFEB);

    // 3: DIV / DIVU
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, bc);
    cmp("t3_busy_len", 32'(bc), 32'd10);
    cmp("t3_div_lo", LO, 32'hFFFF_FFFD);
    cmp("t3_div_hi", HI, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd7, 32'd2, -1, bc);
    cmp("t3_divu_lo", LO, 32'd3);
    cmp("t3_divu_hi", HI, 32'd1);

    // most-negative / -1
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, bc);
    cmp("ovf_lo", LO, 32'h8000_0000);
    cmp("ovf_hi", HI, 32'd0);

    // 5: MTHI then MTLO in consecutive cycles (also sets up test 4)
    @(negedge clk);
    Start = 1'b1; MDOp = OP_MTHI; A = 32'hABCD_0000;
    @(negedge clk);
    cmp("t5_busy_a", {31'd0, Busy}, 32'd0);
    MDOp = OP_MTLO; A = 32'h0000_1234;
    @(negedge clk);
    Start = 1'b0;
    cmp("t5_busy_b", {31'd0, Busy}, 32'd0);
    cmp("t5_hi", HI, 32'hABCD_0000);
    cmp("t5_lo", LO, 32'h0000_1234);

    // 4: divide by zero keeps HI/LO
    run_op(OP_MTHI, 32'h11, 32'd0, -1, bc);
    run_op(OP_MTLO, 32'h22, 32'd0, -1, bc);
    run_op(OP_DIV, 32'd5, 32'd0, -1, bc);
    cmp("t4_busy_len", 32'(bc), 32'd10);
    cmp("t4_hi", HI, 32'h11);
    cmp("t4_lo", LO, 32'h22);

    // 5b: MULT requested mid-run of DIV, and at the commit edge
    run_op(OP_DIVU, 32'd100, 32'd7, 3, bc);
    cmp("t5b_busy_len", 32'(bc), 32'd10);
    cmp("t5b_lo", LO, 32'd14);
    cmp("t5b_hi", HI, 32'd2);
    run_op(OP_DIVU, 32'd9, 32'd4, DIV_N, bc);
    cmp("commit_edge_busy", {31'd0, Busy}, 32'd0);
    cmp("commit_edge_lo", LO, 32'd2);

    // 6: reset three cycles into a MULT
    @(negedge clk);
    Start = 1'b1; MDOp = OP_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("t6_busy", {31'd0, Busy}, 32'd0);
    cmp("t6_hi", HI, 32'd0);
    cmp("t6_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_MULT, 32'd6, 32'hFFFF_FFFE, -1, bc);
    cmp("t6_busy_len", 32'(bc), 32'd5);
    cmp("t6_hi2", HI, 32'hFFFF_FFFF);
    cmp("t6_lo2", LO, 32'hFFFF_FFF4);

    // Randomized phase: free-running requests, including during RUN
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      Start = ($urandom_range(0, 2) == 0);
      MDOp  = 3'($urandom_range(0, 7));
      A     = pick();
      B     = pick();
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    @(negedge clk);
    Start = 1'b0;
    repeat (DIV_N + 2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
